aes128_encrypt_iter: RTL and testbench
======================================

// Module: aes128_encrypt_iter
// PURPOSE
//  Iterative AES-128 encryption core; forward counterpart of the Decryption block.
//  Accepts one 128-bit plaintext plus key per transaction and runs one full round per clock.
//  Expands round keys on the fly and returns ciphertext over a valid/ready handshake.
//  Sits on the datapath side opposite Decryption: its ciphertext is Decryption's input.
// PARAMETERS
//  NK  4   key length in 32-bit words; only 4 is legal.
//  NR  10  number of rounds; only 10 is legal (elaboration error otherwise).
// PORTS
//  clk        in   1    single clock, rising edge
//  reset_n    in   1    asynchronous, active-low reset
//  in_valid   in   1    plaintext/key present
//  in_ready   out  1    core idle, can accept
//  in         in   128  plaintext; in[127:120] = state byte 0 (FIPS-197 column-major order)
//  key        in   128  cipher key, same byte order
//  out_valid  out  1    ciphertext present
//  out_ready  in   1    sink accepts ciphertext
//  out        out  128  ciphertext, same byte order
//  busy       out  1    high while rounds are in progress
// BEHAVIOUR
//  Reset (reset_n low, asynchronous): state IDLE, out=0, out_valid=0, busy=0, round counter=0.
//   Registered state, round key and round counter all clear; in_ready=1 once reset deasserts.
//  FSM states IDLE -> ROUND -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready:
//   - state reg <= in ^ key (round 0 AddRoundKey); round key reg <= key; rnd <= 1; go to ROUND.
//   - in and key are sampled only on this edge; later changes are ignored.
//  ROUND: each cycle computes round rnd:
//   - next round key from current round key via RotWord/SubWord/Rcon[rnd].
//   - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
//   - state <= MixColumns(ShiftRows(SubBytes(state))) ^ next key, for rnd<NR.
//   - rnd==NR omits MixColumns, loads result into out, sets out_valid=1, goes to DONE.
//  Latency: accept edge at cycle 0 -> out_valid high after edge 10 (10 ROUND cycles).
//  DONE: out and out_valid held stable until out_ready=1. On out_valid&&out_ready:
//   - out_valid <= 0, go to IDLE.
//   - out keeps its last value; no combinational in_ready from out_ready.
//  Throughput: one block per 12 cycles with out_ready tied high.
//  in_ready=0 in ROUND and DONE; in_valid there is ignored (no queuing).
//  busy=1 exactly in ROUND.
//  out_ready high while out_valid low: no effect.
//  reset_n asserted mid-ROUND or mid-DONE: transaction discarded, no out_valid pulse.
//  Arithmetic: GF(2^8) xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); S-box is the FIPS-197 table.
// CONFIGURATION
//  AES_ENC_UNROLL2_EN defined: two rounds per ROUND cycle.
//   - Pairs (1,2),(3,4)...(9,10); rnd advances by 2; only round 10 omits MixColumns.
//   - out_valid rises after edge 5; handshake and all other behaviour identical.
//  Not defined: one round per cycle as above.
// TESTING
//  1. key=000102030405060708090a0b0c0d0e0f, in=00112233445566778899aabbccddeeff
//     -> out=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept (5 with UNROLL2).
//  2. key=2b7e151628aed2a6abf7158809cf4f3c, in=3243f6a8885a308d313198a2e0370734
//     -> out=3925841d02dc09fbdc118597196a0b32.
//  3. out_ready held 0 for 20 cycles after out_valid -> out stable, in_ready=0.
//     A new in_valid during this time is not accepted.
//  4. Change in/key on the cycle after accept -> ciphertext still matches the originally sampled vector 1.
//  5. Pulse reset_n low at cycle 4 of ROUND -> out_valid never rises, out=0, in_ready=1 after release.
//     A new vector 1 then yields the correct result.
//  6. Back-to-back vectors 1,2 with out_ready=1 -> both results correct, second accepted 2 cycles after first out_valid.
//     Ciphertext of vector 1 fed to Decryption returns the plaintext 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter -- iterative AES-128 encryption core.
//
// One plaintext/key pair is accepted per transaction. Round 0 (AddRoundKey)
// is applied on the accept edge. After that the core runs one full round per
// clock and derives each round key from the previous one as it goes. The
// ciphertext is returned over a valid/ready handshake.
//
// Optional build macro:
//   AES_ENC_UNROLL2_EN  when defined, two rounds are done per ROUND cycle,
//                       as the pairs (1,2)..(9,10). out_valid then rises 5
//                       edges after accept instead of 10.
//
// Ports:
//   clk        in   1    clock, rising edge
//   reset_n    in   1    asynchronous active-low reset
//   in_valid   in   1    plaintext/key present
//   in_ready   out  1    core idle, can accept
//   in         in   128  plaintext, in[127:120] = state byte 0 (column-major)
//   key        in   128  cipher key, same byte order
//   out_valid  out  1    ciphertext present
//   out_ready  in   1    sink accepts ciphertext
//   out        out  128  ciphertext, same byte order
//   busy       out  1    high while rounds are in progress
module aes128_encrypt_iter #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out,
   output logic         busy
);

   if (NK != 4 || NR != 10) begin : g_bad_param
      $error("aes128_encrypt_iter: only NK=4, NR=10 are supported");
   end

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [3:0] LAST_RND = 4'(NR);

`ifdef AES_ENC_UNROLL2_EN
   localparam logic [3:0] RND_STEP = 4'd2;
`else
   localparam logic [3:0] RND_STEP = 4'd1;
`endif

   // FIPS-197 S-box. Element 0 sits in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // State byte (row, col) is at index row + 4*col, counted from the MSB.
   // ShiftRows rotates row r left by r positions, so it reads column (c+r)%4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[127-8*(row+4*c) -: 8] = sbox(s[127-8*(row+4*((c+row)%4)) -: 8]);
      return r;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] enc_round(input logic [127:0] s,
                                              input logic [127:0] rk,
                                              input logic         last);
      logic [127:0] t;
      t = sub_shift(s);
      if (!last)
         for (int c = 0; c < 4; c++)
            t[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
      return t ^ rk;
   endfunction

   function automatic logic [127:0] key_next(input logic [127:0] rk,
                                             input logic [3:0]   r);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      {w0, w1, w2, w3} = rk;
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(r), 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   logic [1:0]   fsm;
   logic [127:0] state;
   logic [127:0] rkey;
   logic [3:0]   rnd;

   logic [127:0] rk_nxt;
   logic [127:0] st_nxt;
   logic         last;

   // Round logic for the current cycle. In the unrolled build the second
   // half of the pair is the one that may be the final round.
   always_comb begin
      logic [127:0] rk1, st1;
      rk1 = key_next(rkey, rnd);
      st1 = enc_round(state, rk1, rnd == LAST_RND);
`ifdef AES_ENC_UNROLL2_EN
      rk_nxt = key_next(rk1, rnd + 4'd1);
      st_nxt = enc_round(st1, rk_nxt, (rnd + 4'd1) == LAST_RND);
      last   = (rnd + 4'd1) == LAST_RND;
`else
      rk_nxt = rk1;
      st_nxt = st1;
      last   = rnd == LAST_RND;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm       <= IDLE;
         state     <= '0;
         rkey      <= '0;
         rnd       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (fsm)
            IDLE: if (in_valid) begin
               state <= in ^ key;
               rkey  <= key;
               rnd   <= 4'd1;
               fsm   <= ROUND;
            end
            ROUND: if (last) begin
               out       <= st_nxt;
               out_valid <= 1'b1;
               rnd       <= '0;
               fsm       <= DONE;
            end else begin
               state <= st_nxt;
               rkey  <= rk_nxt;
               rnd   <= rnd + RND_STEP;
            end
            DONE: if (out_ready) begin
               // out is left holding the last ciphertext.
               out_valid <= 1'b0;
               fsm       <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign in_ready = (fsm == IDLE);
   assign busy     = (fsm == ROUND);

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed testbench for aes128_encrypt_iter. It uses the known-answer
// vectors from FIPS-197 and checks the handshake, latency, hold, input
// sampling and mid-flight reset behaviour.
module tb_aes128_encrypt_iter;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] din;
   logic [127:0] dkey;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] dout;
   logic         busy;

   int checks;
   int errors;

`ifdef AES_ENC_UNROLL2_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 10;
`endif

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   aes128_encrypt_iter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (din),
      .key       (dkey),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one vector for a single edge. The callers make sure in_ready is high.
   task automatic send(input logic [127:0] p, input logic [127:0] k);
      din      = p;
      dkey     = k;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Counts the edges after the accept edge until out_valid is seen, with a bound.
   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", 128'(out_valid), 128'd1);
   endtask

   initial begin
      int  n;
      logic bad;
      checks    = 0;
      errors    = 0;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      dkey      = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_out",       dout,              128'd0);
      chk("rst_out_valid", 128'(out_valid),   128'd0);
      chk("rst_busy",      128'(busy),        128'd0);
      reset_n = 1'b1;
      tick();
      chk("rst_in_ready",  128'(in_ready),    128'd1);

      // Test 1: vector 1, latency, then handshake
      send(P1, K1);
      chk("t1_busy",     128'(busy),     128'd1);
      chk("t1_in_ready", 128'(in_ready), 128'd0);
      wait_out(n);
      chk("t1_latency",  128'(n),        128'(LAT));
      chk("t1_out",      dout,           C1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t1_valid_drop", 128'(out_valid), 128'd0);
      chk("t1_out_keep",   dout,            C1);
      chk("t1_idle",       128'(in_ready),  128'd1);

      // Tests 2 and 3: vector 2, then the result is held for 20 cycles
      // while a competing in_valid is presented
      send(P2, K2);
      wait_out(n);
      chk("t2_out", dout, C2);
      din = P1; dkey = K1; in_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dout !== C2 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
            bad = 1'b1;
      end
      chk("t3_hold", 128'(bad), 128'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      chk("t3_no_accept", 128'(busy),     128'd0);
      chk("t3_idle",      128'(in_ready), 128'd1);

      // Test 4: the inputs change right after accept
      send(P1, K1);
      din = P2; dkey = K2;
      wait_out(n);
      chk("t4_sampled", dout, C1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Test 5: reset pulse while the rounds are still running
      send(P1, K1);
      repeat (3) tick();
      chk("t5_busy_pre", 128'(busy), 128'd1);
      #2 reset_n = 1'b0;
      #2 reset_n = 1'b1;
      chk("t5_out",      dout,             128'd0);
      chk("t5_in_ready", 128'(in_ready),   128'd1);
      chk("t5_busy",     128'(busy),       128'd0);
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid !== 1'b0) bad = 1'b1;
      end
      chk("t5_no_valid", 128'(bad), 128'd0);
      send(P1, K1);
      wait_out(n);
      chk("t5_retry", dout, C1);
      out_ready = 1'b1;
      tick();

      // Test 6: back-to-back vectors with out_ready held high
      din = P1; dkey = K1; in_valid = 1'b1;
      tick();
      din = P2; dkey = K2;
      wait_out(n);
      chk("t6_out1", dout, C1);
      n = 0;
      while (!busy && n < 10) begin
         tick();
         n++;
      end
      in_valid = 1'b0;
      chk("t6_gap", 128'(n), 128'd2);
      wait_out(n);
      chk("t6_out2", dout, C2);
      tick();
      chk("t6_drain", 128'(out_valid), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
